// File: rtl/music_pkg.sv
// music_pkg: shared types, constant tables and FSM encoding for the melody sequencer.
// Pitch codes 1..12 are C4..B4; code 0 and codes 13..15 are rests.
// Half-period values are in 10 MHz clock cycles, before any tone shift is applied.
package music_pkg;

  localparam int NUM_STEPS = 16;

  typedef logic [3:0] pitch_t;
  typedef logic [3:0] step_t;

`ifdef SEQ_GAP_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } seq_state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1
  } seq_state_t;
`endif

  // Rest codes produce silence and have no table entry.
  function automatic logic is_rest(input pitch_t p);
    return (p == 4'd0) || (p > 4'd12);
  endfunction

  // Half period of each pitch; rests return 0 and are never used for toggling.
  function automatic logic [15:0] half_period(input pitch_t p);
    logic [15:0] hp;
    hp = 16'd0;
    case (p)
      4'd1:    hp = 16'd19111;
      4'd2:    hp = 16'd18039;
      4'd3:    hp = 16'd17026;
      4'd4:    hp = 16'd16071;
      4'd5:    hp = 16'd15169;
      4'd6:    hp = 16'd14317;
      4'd7:    hp = 16'd13514;
      4'd8:    hp = 16'd12755;
      4'd9:    hp = 16'd12039;
      4'd10:   hp = 16'd11364;
      4'd11:   hp = 16'd10726;
      4'd12:   hp = 16'd10124;
      default: hp = 16'd0;
    endcase
    return hp;
  endfunction

  // Fixed 16-step melody: rising run, rest, falling run, rest.
  function automatic pitch_t melody_rom(input step_t s);
    pitch_t p;
    p = 4'd0;
    case (s)
      4'd0:    p = 4'd1;
      4'd1:    p = 4'd3;
      4'd2:    p = 4'd5;
      4'd3:    p = 4'd6;
      4'd4:    p = 4'd8;
      4'd5:    p = 4'd10;
      4'd6:    p = 4'd12;
      4'd7:    p = 4'd0;
      4'd8:    p = 4'd12;
      4'd9:    p = 4'd10;
      4'd10:   p = 4'd8;
      4'd11:   p = 4'd6;
      4'd12:   p = 4'd5;
      4'd13:   p = 4'd3;
      4'd14:   p = 4'd1;
      default: p = 4'd0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/tone_divider.sv
// tone_divider: half-period counter that toggles a square wave every hp cycles.
// Latency: first rising edge hp cycles after restart is released; restart forces output low.
// No backpressure; enable low (rest or not playing) holds the counter and tone at zero.
module tone_divider (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        restart,
  input  logic        enable,
  input  logic [15:0] hp,
  output logic        tone
);

  logic [15:0] cnt_q;

  // Count up to hp-1, then wrap and flip the tone; restart/disable park everything at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 16'd0;
      tone  <= 1'b0;
    end else if (restart || !enable) begin
      cnt_q <= 16'd0;
      tone  <= 1'b0;
    end else if (cnt_q == hp - 16'd1) begin
      cnt_q <= 16'd0;
      tone  <= ~tone;
    end else begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

endmodule

// File: rtl/melody_sequencer.sv
// melody_sequencer: steps a 16-step melody ROM and drives a square-wave tone per step.
// Latency: outputs are registered; a step is entered one cycle after start or note end.
// No backpressure; stop_i wins over everything. Optional articulation gap: SEQ_GAP_EN.
module melody_sequencer #(
  parameter int NOTE_TICKS = 2000000,
  parameter int TONE_SHIFT = 0,
  parameter int GAP_TICKS  = 200000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic       stop_i,
  input  logic       loop_i,
  input  logic [1:0] tempo_i,
  output logic       tone_o,
  output logic [3:0] note_o,
  output logic [3:0] step_o,
  output logic       playing_o,
  output logic       step_stb_o
);

  import music_pkg::*;

  localparam int               CNT_W        = $clog2(NOTE_TICKS + 1);
  localparam logic [CNT_W-1:0] NOTE_LEN_MAX = CNT_W'(NOTE_TICKS);
  localparam step_t            LAST_STEP    = step_t'(NUM_STEPS - 1);

  if (NOTE_TICKS < 1 || TONE_SHIFT < 0 || GAP_TICKS < 0) begin : g_cfg_check
    $error("melody_sequencer: invalid timing parameters");
  end

  seq_state_t       state_q, state_nxt;
  step_t            step_q, step_sel;
  pitch_t           note_q;
  logic [CNT_W-1:0] note_cnt_q, note_len_q, len_sel;
  logic             stb_q;
  logic             step_enter;
  logic             note_end;
  logic [15:0]      tone_hp;
  logic             div_restart, div_enable;

`ifdef SEQ_GAP_EN
  localparam int             GAP_LEN = (GAP_TICKS < 1) ? 1 : GAP_TICKS;
  localparam int             GAP_W   = $clog2(GAP_LEN + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_LEN - 1);

  logic [GAP_W-1:0] gap_cnt_q;
  logic             gap_end;

  assign gap_end = (gap_cnt_q == GAP_LAST);

  // Gap counter runs only while staying in GAP; it is zero on the first gap cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_cnt_q <= '0;
    end else if (state_q == ST_GAP && state_nxt == ST_GAP) begin
      gap_cnt_q <= gap_cnt_q + GAP_W'(1);
    end else begin
      gap_cnt_q <= '0;
    end
  end
`endif

  assign note_end = (note_cnt_q == note_len_q - CNT_W'(1));
  assign step_sel = (state_q == ST_IDLE) ? 4'd0 : step_q + 4'd1;

  // Note length for the step being entered; tempo only matters at step entry.
  always_comb begin
    len_sel = NOTE_LEN_MAX >> tempo_i;
    if (len_sel == '0) begin
      len_sel = CNT_W'(1);
    end
  end

  // Effective half period of the current pitch after the shift, never below one cycle.
  always_comb begin
    tone_hp = half_period(note_q) >> TONE_SHIFT;
    if (tone_hp == 16'd0) begin
      tone_hp = 16'd1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next state and step-entry decision; stop overrides every other transition.
  always_comb begin
    state_nxt  = state_q;
    step_enter = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_nxt  = ST_PLAY;
          step_enter = 1'b1;
        end
      end
      ST_PLAY: begin
        if (note_end) begin
`ifdef SEQ_GAP_EN
          state_nxt = ST_GAP;
`else
          if (step_q != LAST_STEP || loop_i) begin
            step_enter = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
`endif
        end
      end
`ifdef SEQ_GAP_EN
      ST_GAP: begin
        if (gap_end) begin
          if (step_q != LAST_STEP || loop_i) begin
            state_nxt  = ST_PLAY;
            step_enter = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
    if (stop_i) begin
      state_nxt  = ST_IDLE;
      step_enter = 1'b0;
    end
  end

  // Step, pitch and note-length registers; counter stops at its terminal value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q     <= '0;
      note_q     <= '0;
      note_cnt_q <= '0;
      note_len_q <= '0;
      stb_q      <= 1'b0;
    end else begin
      stb_q <= step_enter;
      if (step_enter) begin
        step_q     <= step_sel;
        note_q     <= melody_rom(step_sel);
        note_cnt_q <= '0;
        note_len_q <= len_sel;
      end else if (state_nxt == ST_IDLE) begin
        step_q     <= '0;
        note_q     <= '0;
        note_cnt_q <= '0;
        note_len_q <= '0;
      end else if (state_q == ST_PLAY && !note_end) begin
        note_cnt_q <= note_cnt_q + CNT_W'(1);
      end
    end
  end

  // The tone restarts low on every step entry and whenever playback leaves PLAY.
  assign div_restart = step_enter || (state_nxt != ST_PLAY);
  assign div_enable  = (state_q == ST_PLAY) && !is_rest(note_q);

  tone_divider u_tone_divider (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (div_restart),
    .enable  (div_enable),
    .hp      (tone_hp),
    .tone    (tone_o)
  );

  assign note_o     = note_q;
  assign step_o     = step_q;
  assign playing_o  = (state_q != ST_IDLE);
  assign step_stb_o = stb_q;

endmodule
